// File: rtl/vr_view_change_ctrl.sv
// View-change message builder: sends DoViewChange to the new leader or
// StartView to every other replica, streaming the log behind each header.
module vr_view_change_ctrl #(
  parameter int NUM_REPLICAS = 3,
  parameter int REPLICA_W    = $clog2(NUM_REPLICAS),
  parameter int VIEW_W       = 16,
  parameter int CFG_W        = 48,
  parameter int LEN_W        = 16,
  parameter int DATA_W       = 512
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_val,
  input  logic                 req_mode,
  input  logic [VIEW_W-1:0]    req_view,
  input  logic [REPLICA_W-1:0] req_my_idx,
  output logic                 req_rdy,
  output logic                 cfg_rd_req_val,
  output logic [REPLICA_W-1:0] cfg_rd_req_addr,
  input  logic                 cfg_rd_req_rdy,
  input  logic                 cfg_rd_resp_val,
  input  logic [CFG_W-1:0]     cfg_rd_resp_data,
  output logic                 log_rd_req_val,
  input  logic                 log_rd_req_rdy,
  input  logic                 log_rd_resp_val,
  input  logic [LEN_W-1:0]     log_rd_resp_size,
  input  logic                 log_data_val,
  input  logic [DATA_W-1:0]    log_data,
  input  logic                 log_data_last,
  output logic                 log_data_rdy,
  output logic                 udp_meta_val,
  output logic [CFG_W-1:0]     udp_meta_dst,
  output logic [LEN_W-1:0]     udp_meta_len,
  output logic                 udp_meta_mode,
  input  logic                 udp_meta_rdy,
  output logic                 udp_data_val,
  output logic [DATA_W-1:0]    udp_data,
  output logic                 udp_data_last,
  input  logic                 udp_data_rdy,
  output logic                 done,
  output logic [REPLICA_W:0]   msgs_sent
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CALC,
    S_SEL,
    S_CFG_REQ,
    S_CFG_WAIT,
    S_LOG_REQ,
    S_LOG_WAIT,
    S_META,
    S_DATA,
    S_DONE
  } state_t;

  localparam logic [VIEW_W-1:0]  NR_V  = VIEW_W'(NUM_REPLICAS);
  localparam logic [REPLICA_W:0] NR_D  = (REPLICA_W+1)'(NUM_REPLICAS);
  localparam logic [REPLICA_W:0] ONE_D = (REPLICA_W+1)'(1);

  state_t               r_state;
  logic                 r_mode;
  logic [VIEW_W-1:0]    r_lead_rem;
  logic [REPLICA_W-1:0] r_my_idx;
  logic [REPLICA_W:0]   r_dst_idx;
  logic [CFG_W-1:0]     r_dst_info;
  logic [LEN_W-1:0]     r_log_len;
  logic [REPLICA_W:0]   r_msgs;

  logic w_is_self;
  logic w_in_data;
  logic w_last_hs;

  assign w_is_self = (r_dst_idx == {1'b0, r_my_idx});
  assign w_in_data = (r_state == S_DATA);
  assign w_last_hs = log_data_val & udp_data_rdy & log_data_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_mode     <= 1'b0;
      r_lead_rem <= '0;
      r_my_idx   <= '0;
      r_dst_idx  <= '0;
      r_dst_info <= '0;
      r_log_len  <= '0;
      r_msgs     <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (req_val) begin
            r_mode     <= req_mode;
            r_lead_rem <= req_view;
            r_my_idx   <= req_my_idx;
            r_msgs     <= '0;
            r_state    <= S_CALC;
          end
        end
        // view mod N by repeated subtraction, one step per cycle
        S_CALC: begin
          if (r_lead_rem >= NR_V) begin
            r_lead_rem <= r_lead_rem - NR_V;
          end else begin
            r_dst_idx <= r_mode ? '0
                       : {1'b0, r_lead_rem[REPLICA_W-1:0]};
            r_state   <= S_SEL;
          end
        end
        S_SEL: begin
          if (!r_mode) begin
            r_state <= w_is_self ? S_DONE : S_CFG_REQ;
          end else if (r_dst_idx == NR_D) begin
            r_state <= S_DONE;
          end else if (w_is_self) begin
            r_dst_idx <= r_dst_idx + ONE_D;
          end else begin
            r_state <= S_CFG_REQ;
          end
        end
        S_CFG_REQ: begin
          if (cfg_rd_req_rdy) r_state <= S_CFG_WAIT;
        end
        S_CFG_WAIT: begin
          if (cfg_rd_resp_val) begin
            r_dst_info <= cfg_rd_resp_data;
            r_state    <= S_LOG_REQ;
          end
        end
        S_LOG_REQ: begin
          if (log_rd_req_rdy) r_state <= S_LOG_WAIT;
        end
        S_LOG_WAIT: begin
          if (log_rd_resp_val) begin
            r_log_len <= log_rd_resp_size;
            r_state   <= S_META;
          end
        end
        S_META: begin
          if (udp_meta_rdy) r_state <= S_DATA;
        end
        S_DATA: begin
          if (w_last_hs) begin
            r_msgs <= r_msgs + ONE_D;
            if (r_mode) begin
              r_dst_idx <= r_dst_idx + ONE_D;
              r_state   <= S_SEL;
            end else begin
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_rdy         = (r_state == S_IDLE);
  assign cfg_rd_req_val  = (r_state == S_CFG_REQ);
  assign cfg_rd_req_addr = r_dst_idx[REPLICA_W-1:0];
  assign log_rd_req_val  = (r_state == S_LOG_REQ);
  assign udp_meta_val    = (r_state == S_META);
  assign udp_meta_dst    = r_dst_info;
  assign udp_meta_len    = r_log_len;
  assign udp_meta_mode   = r_mode;
  // payload is a zero-latency passthrough gated to the data phase
  assign udp_data_val    = w_in_data & log_data_val;
  assign udp_data        = log_data;
  assign udp_data_last   = w_in_data & log_data_last;
  assign log_data_rdy    = w_in_data & udp_data_rdy;
  assign done            = (r_state == S_DONE);
  assign msgs_sent       = r_msgs;

endmodule

// File: tb/tb_vr_view_change_ctrl.sv
// Bench for vr_view_change_ctrl: N=3 and N=5 instances sharing one
// responder for config RAM, log reader and UDP TX.
module tb_vr_view_change_ctrl;

  localparam int DW = 512;

  typedef struct {
    bit          n5;
    bit          mode;
    logic [15:0] view;
    logic [2:0]  my;
    int          beats;
    bit          bp;
    int          msgs;
    logic [15:0] addrs;
    int          lat;
    int          inject;
  } vec_t;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  typedef struct {
    logic [47:0] dst;
    logic [15:0] len;
    logic        mode;
  } meta_t;

  logic clk = 0;
  logic rst;
  logic req_val3, req_val5, req_mode;
  logic [15:0] req_view;
  logic [2:0] req_my;
  logic cfg_rd_req_rdy, cfg_rd_resp_val;
  logic [47:0] cfg_rd_resp_data;
  logic log_rd_req_rdy, log_rd_resp_val;
  logic [15:0] log_rd_resp_size;
  logic log_data_val, log_data_last;
  logic [DW-1:0] log_data;
  logic udp_meta_rdy, udp_data_rdy;

  logic rr3, cv3, lv3, ldr3, mv3, mm3, dv3, dl3, dn3;
  logic [1:0] ca3;
  logic [47:0] md3;
  logic [15:0] ml3;
  logic [DW-1:0] dd3;
  logic [2:0] ms3;
  logic rr5, cv5, lv5, ldr5, mv5, mm5, dv5, dl5, dn5;
  logic [2:0] ca5;
  logic [47:0] md5;
  logic [15:0] ml5;
  logic [DW-1:0] dd5;
  logic [3:0] ms5;

  always #5 clk = ~clk;

  vr_view_change_ctrl #(.NUM_REPLICAS(3)) dut3 (
    .clk(clk), .rst(rst),
    .req_val(req_val3), .req_mode(req_mode), .req_view(req_view),
    .req_my_idx(req_my[1:0]), .req_rdy(rr3),
    .cfg_rd_req_val(cv3), .cfg_rd_req_addr(ca3),
    .cfg_rd_req_rdy(cfg_rd_req_rdy), .cfg_rd_resp_val(cfg_rd_resp_val),
    .cfg_rd_resp_data(cfg_rd_resp_data),
    .log_rd_req_val(lv3), .log_rd_req_rdy(log_rd_req_rdy),
    .log_rd_resp_val(log_rd_resp_val), .log_rd_resp_size(log_rd_resp_size),
    .log_data_val(log_data_val), .log_data(log_data),
    .log_data_last(log_data_last), .log_data_rdy(ldr3),
    .udp_meta_val(mv3), .udp_meta_dst(md3), .udp_meta_len(ml3),
    .udp_meta_mode(mm3), .udp_meta_rdy(udp_meta_rdy),
    .udp_data_val(dv3), .udp_data(dd3), .udp_data_last(dl3),
    .udp_data_rdy(udp_data_rdy), .done(dn3), .msgs_sent(ms3)
  );

  vr_view_change_ctrl #(.NUM_REPLICAS(5)) dut5 (
    .clk(clk), .rst(rst),
    .req_val(req_val5), .req_mode(req_mode), .req_view(req_view),
    .req_my_idx(req_my), .req_rdy(rr5),
    .cfg_rd_req_val(cv5), .cfg_rd_req_addr(ca5),
    .cfg_rd_req_rdy(cfg_rd_req_rdy), .cfg_rd_resp_val(cfg_rd_resp_val),
    .cfg_rd_resp_data(cfg_rd_resp_data),
    .log_rd_req_val(lv5), .log_rd_req_rdy(log_rd_req_rdy),
    .log_rd_resp_val(log_rd_resp_val), .log_rd_resp_size(log_rd_resp_size),
    .log_data_val(log_data_val), .log_data(log_data),
    .log_data_last(log_data_last), .log_data_rdy(ldr5),
    .udp_meta_val(mv5), .udp_meta_dst(md5), .udp_meta_len(ml5),
    .udp_meta_mode(mm5), .udp_meta_rdy(udp_meta_rdy),
    .udp_data_val(dv5), .udp_data(dd5), .udp_data_last(dl5),
    .udp_data_rdy(udp_data_rdy), .done(dn5), .msgs_sent(ms5)
  );

  bit sel5 = 0;
  bit bp = 0;
  int cur_beats = 1;

  logic a_rr, a_cv, a_lv, a_ldr, a_mv, a_mm, a_dv, a_dl, a_dn;
  logic [2:0] a_ca;
  logic [47:0] a_md;
  logic [15:0] a_ml;
  logic [DW-1:0] a_dd;
  logic [3:0] a_ms;

  assign a_rr  = sel5 ? rr5 : rr3;
  assign a_cv  = sel5 ? cv5 : cv3;
  assign a_ca  = sel5 ? ca5 : {1'b0, ca3};
  assign a_lv  = sel5 ? lv5 : lv3;
  assign a_ldr = sel5 ? ldr5 : ldr3;
  assign a_mv  = sel5 ? mv5 : mv3;
  assign a_md  = sel5 ? md5 : md3;
  assign a_ml  = sel5 ? ml5 : ml3;
  assign a_mm  = sel5 ? mm5 : mm3;
  assign a_dv  = sel5 ? dv5 : dv3;
  assign a_dd  = sel5 ? dd5 : dd3;
  assign a_dl  = sel5 ? dl5 : dl3;
  assign a_dn  = sel5 ? dn5 : dn3;
  assign a_ms  = sel5 ? ms5 : {1'b0, ms3};

  int checks = 0;
  int errors = 0;

  task automatic chk(input bit ok, input string nm,
                     input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [47:0] cfg_of(input logic [2:0] a);
    return 48'hC0A8_0001_1388 + {29'd0, a, 16'd0};
  endfunction

  function automatic logic [DW-1:0] pat(input int m, input int b);
    logic [31:0] w;
    w = 32'hA5A5_0000 ^ 32'(m * 16 + b);
    return {16{w}};
  endfunction

  function automatic bit rnd();
    return bp ? ($urandom_range(0, 1) == 1) : 1'b1;
  endfunction

  logic [2:0] addr_q[$];
  meta_t      meta_q[$];
  beat_t      src_q[$];
  beat_t      exp_q[$];
  int nlogreq = 0;
  int beat_cnt = 0;
  int msgid = 0;

  // environment: config RAM, log reader and TX sink
  initial begin
    int cfg_cnt, log_cnt;
    bit src_acc, m_hold, c_hold;
    logic [47:0] m_dst;
    logic [15:0] m_len;
    logic [2:0] c_addr;
    beat_t bt;
    cfg_cnt = 0; log_cnt = 0; src_acc = 0; m_hold = 0; c_hold = 0;
    m_dst = '0; m_len = '0; c_addr = '0;
    cfg_rd_req_rdy = 0; cfg_rd_resp_val = 0; cfg_rd_resp_data = '0;
    log_rd_req_rdy = 0; log_rd_resp_val = 0; log_rd_resp_size = '0;
    log_data_val = 0; log_data = '0; log_data_last = 0;
    udp_meta_rdy = 0; udp_data_rdy = 0;
    forever begin
      @(negedge clk);
      cfg_rd_resp_val = 0;
      log_rd_resp_val = 0;
      if (cfg_cnt > 0) begin cfg_cnt--; cfg_rd_resp_val = (cfg_cnt == 0); end
      if (log_cnt > 0) begin log_cnt--; log_rd_resp_val = (log_cnt == 0); end
      cfg_rd_req_rdy = rnd();
      log_rd_req_rdy = rnd();
      udp_meta_rdy   = rnd();
      udp_data_rdy   = rnd();
      if (src_acc || !log_data_val)
        log_data_val = (src_q.size() > 0) && rnd();
      src_acc = 0;
      if (src_q.size() > 0) begin
        log_data = src_q[0].d;
        log_data_last = src_q[0].l;
      end
      #1;
      if (rst) begin
        src_q.delete(); exp_q.delete();
        cfg_cnt = 0; log_cnt = 0; m_hold = 0; c_hold = 0;
        log_data_val = 0; log_data_last = 0;
      end else begin
        if (m_hold) begin
          chk(a_mv, "meta_val_held", 64'(a_mv), 64'd1);
          chk(a_md == m_dst && a_ml == m_len, "meta_stable",
              64'(a_md), 64'(m_dst));
        end
        m_hold = a_mv && !udp_meta_rdy; m_dst = a_md; m_len = a_ml;
        if (c_hold) chk(a_cv && a_ca == c_addr, "cfg_req_held",
                        64'(a_ca), 64'(c_addr));
        c_hold = a_cv && !cfg_rd_req_rdy; c_addr = a_ca;
        if (a_cv && cfg_rd_req_rdy) begin
          addr_q.push_back(a_ca);
          cfg_rd_resp_data = cfg_of(a_ca);
          cfg_cnt = 1 + (bp ? $urandom_range(0, 2) : 0);
        end
        if (a_lv && log_rd_req_rdy) begin
          nlogreq++;
          log_rd_resp_size = 16'(cur_beats * 64);
          log_cnt = 1 + (bp ? $urandom_range(0, 2) : 0);
          for (int b = 0; b < cur_beats; b++) begin
            bt.d = pat(msgid, b);
            bt.l = (b == cur_beats - 1);
            src_q.push_back(bt);
            exp_q.push_back(bt);
          end
          msgid++;
        end
        if (a_mv && udp_meta_rdy)
          meta_q.push_back('{dst: a_md, len: a_ml, mode: a_mm});
        if (log_data_val && a_ldr && src_q.size() > 0) begin
          void'(src_q.pop_front());
          src_acc = 1;
        end
        if (a_dv && udp_data_rdy) begin
          if (exp_q.size() == 0) begin
            chk(0, "extra_beat", 64'(a_dd), 64'd0);
          end else begin
            bt = exp_q.pop_front();
            chk(a_dd == bt.d, "beat_data", a_dd[63:0], bt.d[63:0]);
            chk(a_dl == bt.l, "beat_last", 64'(a_dl), 64'(bt.l));
          end
          beat_cnt++;
        end
      end
    end
  end

  task automatic run_vec(input vec_t v, input int id);
    int k;
    logic [15:0] ea;
    addr_q.delete(); meta_q.delete();
    nlogreq = 0; beat_cnt = 0;
    @(negedge clk);
    sel5 = v.n5; bp = v.bp; cur_beats = v.beats;
    req_mode = v.mode; req_view = v.view; req_my = v.my;
    chk(a_rr, $sformatf("v%0d_req_rdy_idle", id), 64'(a_rr), 64'd1);
    if (v.n5) req_val5 = 1; else req_val3 = 1;
    @(negedge clk);
    req_val3 = 0; req_val5 = 0;
    k = 1;
    while (!a_dn && k < 3000) begin
      if (v.inject > 0 && k == v.inject) begin
        chk(!a_rr, $sformatf("v%0d_busy_rdy", id), 64'(a_rr), 64'd0);
        req_mode = 0; req_view = 16'd1; req_my = 3'd0;
        req_val5 = 1;
      end
      @(negedge clk);
      req_val5 = 0;
      k++;
    end
    if (!a_dn) begin
      chk(0, $sformatf("v%0d_done_timeout", id), 64'(k), 64'd3000);
    end else begin
      if (v.lat >= 0)
        chk(k - 1 == v.lat, $sformatf("v%0d_latency", id),
            64'(k - 1), 64'(v.lat));
      chk(a_ms == 4'(v.msgs), $sformatf("v%0d_msgs_sent", id),
          64'(a_ms), 64'(v.msgs));
    end
    @(negedge clk);
    chk(!a_dn && a_rr, $sformatf("v%0d_done_pulse", id),
        64'({a_dn, a_rr}), 64'b01);
    repeat (5) @(negedge clk);
    #2;
    chk(a_ms == 4'(v.msgs), $sformatf("v%0d_msgs_hold", id),
        64'(a_ms), 64'(v.msgs));
    chk(addr_q.size() == v.msgs, $sformatf("v%0d_cfg_cnt", id),
        64'(addr_q.size()), 64'(v.msgs));
    chk(meta_q.size() == v.msgs, $sformatf("v%0d_meta_cnt", id),
        64'(meta_q.size()), 64'(v.msgs));
    chk(nlogreq == v.msgs, $sformatf("v%0d_log_cnt", id),
        64'(nlogreq), 64'(v.msgs));
    chk(exp_q.size() == 0, $sformatf("v%0d_beats_left", id),
        64'(exp_q.size()), 64'd0);
    ea = v.addrs;
    for (int i = 0; i < v.msgs; i++) begin
      if (i < addr_q.size())
        chk(addr_q[i] == ea[4*i +: 3], $sformatf("v%0d_addr%0d", id, i),
            64'(addr_q[i]), 64'(ea[4*i +: 3]));
      if (i < meta_q.size()) begin
        chk(meta_q[i].dst == cfg_of(ea[4*i +: 3]),
            $sformatf("v%0d_dst%0d", id, i),
            64'(meta_q[i].dst), 64'(cfg_of(ea[4*i +: 3])));
        chk(meta_q[i].len == 16'(v.beats * 64) && meta_q[i].mode == v.mode,
            $sformatf("v%0d_len_mode%0d", id, i),
            64'({meta_q[i].mode, meta_q[i].len}),
            64'({v.mode, 16'(v.beats * 64)}));
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[11];
    int k;
    rst = 1; req_val3 = 0; req_val5 = 0; req_mode = 0;
    req_view = '0; req_my = '0;
    //          n5 md view    my  bt bp ms addrs    lat inj
    vt[0]  = '{0, 0, 16'd7,  3'd0, 1, 0, 1, 16'h0001, 10, 0};
    vt[1]  = '{0, 0, 16'd6,  3'd0, 1, 0, 0, 16'h0000, 4,  0};
    vt[2]  = '{1, 1, 16'd9,  3'd2, 2, 0, 4, 16'h4310, 36, 0};
    vt[3]  = '{0, 1, 16'd0,  3'd1, 1, 0, 2, 16'h0020, 17, 0};
    vt[4]  = '{0, 0, 16'd2,  3'd0, 3, 0, 1, 16'h0002, 10, 0};
    vt[5]  = '{1, 0, 16'd13, 3'd3, 1, 0, 0, 16'h0000, 4,  0};
    vt[6]  = '{1, 0, 16'd14, 3'd3, 2, 0, 1, 16'h0004, 11, 0};
    vt[7]  = '{1, 1, 16'd0,  3'd4, 1, 0, 4, 16'h3210, 31, 0};
    vt[8]  = '{1, 1, 16'd3,  3'd0, 1, 0, 4, 16'h4321, 31, 10};
    vt[9]  = '{0, 0, 16'd7,  3'd2, 3, 1, 1, 16'h0001, -1, 0};
    vt[10] = '{1, 1, 16'd9,  3'd2, 3, 1, 4, 16'h4310, -1, 0};

    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk(rr3 && rr5, "rst_req_rdy", 64'({rr3, rr5}), 64'b11);
    chk({cv3, lv3, mv3, dv3, ldr3, dl3, dn3} == '0, "rst_vals3",
        64'({cv3, lv3, mv3, dv3, ldr3, dl3, dn3}), 64'd0);
    chk({cv5, lv5, mv5, dv5, ldr5, dl5, dn5} == '0, "rst_vals5",
        64'({cv5, lv5, mv5, dv5, ldr5, dl5, dn5}), 64'd0);
    chk(ms3 == '0 && ms5 == '0, "rst_msgs", 64'({ms3, ms5}), 64'd0);
    chk(md3 == '0 && ml3 == '0 && md5 == '0 && ml5 == '0, "rst_dst_len",
        64'(md3 | md5 | 48'(ml3) | 48'(ml5)), 64'd0);

    for (int i = 0; i < 11; i++) run_vec(vt[i], i);

    // reset while the third of four beats is pending
    addr_q.delete(); meta_q.delete(); nlogreq = 0; beat_cnt = 0;
    @(negedge clk);
    sel5 = 0; bp = 0; cur_beats = 4;
    req_mode = 0; req_view = 16'd7; req_my = 3'd0; req_val3 = 1;
    @(negedge clk);
    req_val3 = 0;
    k = 0;
    while (beat_cnt < 2 && k < 200) begin @(negedge clk); k++; end
    chk(beat_cnt == 2, "rst_mid_beats", 64'(beat_cnt), 64'd2);
    chk(a_dv, "rst_mid_in_data", 64'(a_dv), 64'd1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk(a_rr, "rst_mid_req_rdy", 64'(a_rr), 64'd1);
    chk({a_cv, a_lv, a_mv, a_dv, a_ldr, a_dn} == '0, "rst_mid_vals",
        64'({a_cv, a_lv, a_mv, a_dv, a_ldr, a_dn}), 64'd0);
    chk(a_ms == '0, "rst_mid_msgs", 64'(a_ms), 64'd0);
    run_vec(vt[0], 11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
